// File: rtl/uart_tx_if.sv
// Producer-to-transmitter byte handshake (STB/DAT in, one-cycle ACK out).
interface uart_tx_if;
    logic       STBi;
    logic [7:0] DATi;
    logic       ACKi;

    modport master (output STBi, output DATi, input ACKi);
    modport slave  (input STBi, input DATi, output ACKi);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: double-buffered 8N1 UART transmitter, LSB first, idle-high TXD.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects sense).
module uart_tx #(
    parameter int unsigned PRESCALER  = 434,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic     CLK,
    input  logic     RST_N,
    uart_tx_if.slave prod,
    output logic     TXD,
    output logic     BUSY
);

    if (PRESCALER < 2 || PRESCALER > 65535) begin : g_bad_ps
        $error("uart_tx: PRESCALER out of range");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx: STOP_BITS or PARITY_ODD out of range");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, BIT, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;
`endif

    localparam logic [15:0] PS_MAX    = 16'(PRESCALER - 1);
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    state_t      state_q, state_d;
    logic [15:0] ps_q, ps_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop_q, stop_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hv_q, hv_d;
    logic        ack_q, ack_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        hv_d    = hv_q;
        ack_d   = 1'b0;
        txd_d   = txd_q;
        busy_d  = (state_q != IDLE) || hv_q;
        tick    = (ps_q == 16'd0);
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (prod.STBi && !hv_q && !ack_q) begin
            hold_d = prod.DATi;
            hv_d   = 1'b1;
            ack_d  = 1'b1;
        end

        if (state_q != IDLE) begin
            ps_d = tick ? PS_MAX : ps_q - 16'd1;
        end

        unique case (state_q)
            IDLE: load = hv_q;
            START: begin
                if (tick) begin
                    state_d = BIT;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            BIT: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        stop_d  = 1'b0;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_q != STOP_LAST) begin
                        stop_d = 1'b1;
                    end else if (hv_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A pending byte starts its frame on the very edge the line frees up.
        if (load) begin
            state_d = START;
            txd_d   = 1'b0;
            ps_d    = PS_MAX;
            shift_d = hold_q;
            hv_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^hold_q) ^ PARITY_ODD[0];
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ps_q    <= PS_MAX;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            shift_q <= 8'd0;
            hold_q  <= 8'd0;
            hv_q    <= 1'b0;
            ack_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            hv_q    <= hv_d;
            ack_q   <= ack_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign prod.ACKi = ack_q;
    assign TXD       = txd_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters (P=8/1 stop, P=4/2 stop) checked each cycle
// against a per-cycle line-waveform model built from frame rules.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FR0 = (10 + PAR) * 8;
    localparam int FR1 = (11 + PAR) * 4;

    logic       clk;
    logic [1:0] rst_n;
    logic       txd0, busy0, txd1, busy1;

    uart_tx_if if0 ();
    uart_tx_if if1 ();

    uart_tx #(.PRESCALER(8), .STOP_BITS(1)) dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .prod(if0), .TXD(txd0), .BUSY(busy0)
    );
    uart_tx #(.PRESCALER(4), .STOP_BITS(2)) dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .prod(if1), .TXD(txd1), .BUSY(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecs;
    int errs;

    // model: future line level per cycle, holding register, ack, busy
    bit       mq [2][$];
    bit       m_hv [2];
    bit       m_ack [2];
    bit       m_busy [2];
    bit [7:0] m_hold [2];

    bit       ht [2][$];
    bit       hb [2][$];
    bit       ha [2][$];

    bit [7:0] pend [2][$];
    int       gap [2];
    bit       rnd_gap;

    function automatic int psc(int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int stopb(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic dtxd(int i);
        return (i == 0) ? txd0 : txd1;
    endfunction

    function automatic logic dbusy(int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    function automatic logic dack(int i);
        return (i == 0) ? if0.ACKi : if1.ACKi;
    endfunction

    function automatic logic get_stb(int i);
        return (i == 0) ? if0.STBi : if1.STBi;
    endfunction

    function automatic logic [7:0] get_dat(int i);
        return (i == 0) ? if0.DATi : if1.DATi;
    endfunction

    task automatic set_in(int i, logic s, logic [7:0] d);
        if (i == 0) begin
            if0.STBi = s;
            if0.DATi = d;
        end else begin
            if1.STBi = s;
            if1.DATi = d;
        end
    endtask

    task automatic chk(string nm, int i, logic act, logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] t=%0t: got %b expected %b",
                     nm, i, $time, act, exp);
        end
    endtask

    task automatic push_frame(int i, bit [7:0] b);
        bit bits[$];
        int p;
        p = psc(i);
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        for (int k = 0; k < stopb(i); k++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (p) mq[i].push_back(bits[k]);
    endtask

    // advance the model across one rising edge using pre-edge inputs
    task automatic mstep(int i);
        bit act;
        bit hv;
        if (!rst_n[i]) begin
            mq[i].delete();
            m_hv[i]   = 1'b0;
            m_ack[i]  = 1'b0;
            m_busy[i] = 1'b0;
            return;
        end
        act = (mq[i].size() != 0);
        hv  = m_hv[i];
        m_busy[i] = act || hv;
        if (act) void'(mq[i].pop_front());
        if (hv && mq[i].size() == 0) begin
            push_frame(i, m_hold[i]);
            m_hv[i] = 1'b0;
        end
        if (get_stb(i) && !hv && !m_ack[i]) begin
            m_hv[i]   = 1'b1;
            m_hold[i] = get_dat(i);
            m_ack[i]  = 1'b1;
        end else begin
            m_ack[i] = 1'b0;
        end
    endtask

    task automatic drive(int i);
        if (pend[i].size() != 0 && gap[i] == 0) begin
            set_in(i, 1'b1, pend[i][0]);
        end else begin
            set_in(i, 1'b0, 8'h00);
            if (gap[i] > 0) gap[i]--;
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) mstep(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("txd", i, dtxd(i), (mq[i].size() != 0) ? mq[i][0] : 1'b1);
            chk("busy", i, dbusy(i), m_busy[i]);
            chk("ack", i, dack(i), m_ack[i]);
            ht[i].push_back(dtxd(i));
            hb[i].push_back(dbusy(i));
            ha[i].push_back(dack(i));
            if (dack(i) === 1'b1 && pend[i].size() != 0) begin
                void'(pend[i].pop_front());
                if (rnd_gap && $urandom_range(0, 1) == 1)
                    gap[i] = $urandom_range(1, 120);
                else
                    gap[i] = 0;
            end
            drive(i);
        end
    endtask

    task automatic clr_hist();
        for (int i = 0; i < 2; i++) begin
            ht[i].delete();
            hb[i].delete();
            ha[i].delete();
        end
    endtask

    function automatic int nack(int i);
        int n;
        n = 0;
        for (int k = 0; k < ha[i].size(); k++) n += int'(ha[i][k]);
        return n;
    endfunction

    initial begin
        bit [10:0] ea5;
        int        t;
        vecs    = 0;
        errs    = 0;
        rnd_gap = 1'b0;
        gap[0]  = 0;
        gap[1]  = 0;
        rst_n   = 2'b00;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (3) tick();
        rst_n = 2'b11;

        // quiet line after reset
        repeat (1000) tick();
        chk("idle_txd", 0, txd0, 1'b1);
        chk("idle_busy", 0, busy0, 1'b0);
        chk("idle_txd", 1, txd1, 1'b1);

        // single byte 0xA5
`ifdef UART_TX_PARITY_EN
        ea5 = 11'b10100101010;
`else
        ea5 = 11'b01101001010;
`endif
        clr_hist();
        pend[0].push_back(8'hA5);
        drive(0);
        repeat (FR0 + 20) tick();
        chk("a5_ack0", 0, ha[0][0], 1'b1);
        chk("a5_ack1", 0, ha[0][1], 1'b0);
        chk("a5_pre", 0, ht[0][0], 1'b1);
        chk("a5_fall", 0, ht[0][1], 1'b0);
        for (int k = 0; k < 10 + PAR; k++)
            chk("a5_bit", k, ht[0][1 + 8 * k + 4], ea5[k]);
        chk("a5_busy_on", 0, hb[0][1], 1'b1);
        chk("a5_busy_end", 0, hb[0][FR0 + 1], 1'b1);
        chk("a5_busy_off", 0, hb[0][FR0 + 2], 1'b0);

        // back-to-back 0x00 then 0xFF with STBi held
        clr_hist();
        pend[0].push_back(8'h00);
        pend[0].push_back(8'hFF);
        drive(0);
        repeat (2 * FR0 + 20) tick();
        chk("b2b_ack2", 0, ha[0][2], 1'b1);
        chk("b2b_nack", 0, 1'(nack(0) == 2), 1'b1);
        chk("b2b_stop", 0, ht[0][FR0], 1'b1);
        chk("b2b_start2", 0, ht[0][FR0 + 1], 1'b0);
        chk("b2b_busy_mid", 0, hb[0][FR0 + 1], 1'b1);
        chk("b2b_busy_off", 0, hb[0][2 * FR0 + 2], 1'b0);

        // two stop bits, P=4, 0x3C
        clr_hist();
        pend[1].push_back(8'h3C);
        drive(1);
        repeat (FR1 + 20) tick();
        chk("s2_start", 1, ht[1][1], 1'b0);
        chk("s2_last0", 1, ht[1][36 + 4 * PAR], 1'b0);
        for (int k = 0; k < 8; k++)
            chk("s2_stop", k, ht[1][37 + 4 * PAR + k], 1'b1);
        chk("s2_busy_end", 1, hb[1][FR1 + 1], 1'b1);
        chk("s2_busy_off", 1, hb[1][FR1 + 2], 1'b0);

        // reset during data bit 3 of 0x55
        clr_hist();
        pend[0].push_back(8'h55);
        drive(0);
        repeat (36) tick();
        chk("rst_bit3", 0, ht[0][35], 1'b0);
        #2;
        rst_n[0] = 1'b0;
        pend[0].delete();
        set_in(0, 1'b0, 8'h00);
        #1;
        chk("rst_txd", 0, txd0, 1'b1);
        chk("rst_busy", 0, busy0, 1'b0);
        repeat (3) tick();
        rst_n[0] = 1'b1;
        repeat (200) tick();
        chk("rst_after_txd", 0, txd0, 1'b1);
        chk("rst_after_busy", 0, busy0, 1'b0);

        // random bytes with random gaps on both transmitters
        clr_hist();
        rnd_gap = 1'b1;
        for (int n = 0; n < 30; n++) begin
            pend[0].push_back(8'($urandom_range(0, 255)));
            pend[1].push_back(8'($urandom_range(0, 255)));
        end
        drive(0);
        drive(1);
        t = 0;
        while ((pend[0].size() != 0 || pend[1].size() != 0 ||
                mq[0].size() != 0 || mq[1].size() != 0 ||
                m_hv[0] || m_hv[1]) && t < 30000) begin
            tick();
            t++;
        end
        if (t >= 30000) begin
            vecs++;
            errs++;
            $display("FAIL rnd_timeout: stuck after %0d cycles", t);
        end
        repeat (5) tick();
        chk("rnd_nack", 0, 1'(nack(0) == 30), 1'b1);
        chk("rnd_nack", 1, 1'(nack(1) == 30), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
